// File: rtl/ising_readout_pkg.sv
// +----------------------------------------------------------------------+
// | ising_readout_pkg: FSM encoding and default parameters for readout    |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

package ising_readout_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam int DEF_N             = 6;
  localparam int DEF_SETTLE_CYCLES = 64;
  localparam int DEF_SAMPLE_CYCLES = 32;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ising_readout_sync_2ff.sv
// +----------------------------------------------------------------------+
// | sync_2ff: per-bit two-flop synchronizer, async active-low reset       |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

`default_nettype wire

// File: rtl/ising_readout.sv
// +----------------------------------------------------------------------+
// | ising_readout: majority phase readout of an oscillator Ising array.   |
// | Optional macro ISING_READOUT_CANON_EN canonicalizes so spin[0]==0.    |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module ising_readout
  import ising_readout_pkg::*;
#(
  parameter int N             = DEF_N,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int SAMPLE_CYCLES = DEF_SAMPLE_CYCLES
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         start,
  input  logic [N-1:0] osc_in,
  output logic         busy,
  output logic [N-2:0] spin,
  output logic         spin_valid,
  input  logic         spin_ready
);

  localparam int CW = $clog2(SAMPLE_CYCLES + 1);
  localparam int TW = $clog2(max_int(SETTLE_CYCLES, SAMPLE_CYCLES) + 1);

  state_e                 state_q, state_d;
  logic [TW-1:0]          tmr_q, tmr_d;
  logic [N-2:0][CW-1:0]   cnt_q, cnt_d;
  logic [N-2:0]           spin_q, spin_d;
  logic                   valid_q, valid_d;
  logic [N-1:0]           osc_sync;
  logic [N-2:0]           raw;
  logic [N-2:0]           result;

  sync_2ff #(
    .WIDTH (N)
  ) u_sync (
    .clk  (clk),
    .rstn (rstn),
    .d_i  (osc_in),
    .q_o  (osc_sync)
  );

  // Strict majority: a tie (2*count == SAMPLE_CYCLES) reads as in-phase.
  for (genvar gi = 0; gi < N - 1; gi++) begin : g_major
    assign raw[gi] = {cnt_q[gi], 1'b0} > (CW + 1)'(SAMPLE_CYCLES);
  end

`ifdef ISING_READOUT_CANON_EN
  assign result = raw[0] ? ~raw : raw;
`else
  assign result = raw;
`endif

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    cnt_d   = cnt_q;
    spin_d  = spin_q;
    valid_d = valid_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SETTLE;
          tmr_d   = '0;
        end
      end
      ST_SETTLE: begin
        if (tmr_q == TW'(SETTLE_CYCLES - 1)) begin
          state_d = ST_SAMPLE;
          tmr_d   = '0;
          cnt_d   = '0;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      ST_SAMPLE: begin
        // One extra cycle after the last sample registers the decision.
        if (tmr_q == TW'(SAMPLE_CYCLES)) begin
          spin_d  = result;
          valid_d = 1'b1;
          state_d = ST_DONE;
        end else begin
          tmr_d = tmr_q + TW'(1);
          for (int i = 0; i < N - 1; i++) begin
            if ((osc_sync[i] ^ osc_sync[N-1]) && (cnt_q[i] != CW'(SAMPLE_CYCLES))) begin
              cnt_d[i] = cnt_q[i] + CW'(1);
            end
          end
        end
      end
      ST_DONE: begin
        if (valid_q && spin_ready) begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      tmr_q   <= '0;
      cnt_q   <= '0;
      spin_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      cnt_q   <= cnt_d;
      spin_q  <= spin_d;
      valid_q <= valid_d;
    end
  end

  assign busy       = (state_q != ST_IDLE);
  assign spin       = spin_q;
  assign spin_valid = valid_q;

endmodule

`default_nettype wire

// File: tb/tb_ising_readout.sv
// +----------------------------------------------------------------------+
// | tb_ising_readout: scoreboard bench for ising_readout (N=6, 4/8 cyc)   |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_ising_readout;

  localparam int N   = 6;
  localparam int S   = 4;
  localparam int M   = 8;
  localparam int LAT = S + M + 1;

  localparam int MODE_MAXCUT = 0;
  localparam int MODE_TIE4   = 1;
  localparam int MODE_MAJ5   = 2;
  localparam int MODE_RAW    = 3;

  logic         clk        = 1'b0;
  logic         rstn       = 1'b1;
  logic         start      = 1'b0;
  logic [N-1:0] osc_in     = '0;
  logic         spin_ready = 1'b1;
  logic         busy;
  logic [N-2:0] spin;
  logic         spin_valid;

  int checks   = 0;
  int failures = 0;
  logic [N-2:0] exp_q[$];

  ising_readout #(
    .N             (N),
    .SETTLE_CYCLES (S),
    .SAMPLE_CYCLES (M)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .start      (start),
    .osc_in     (osc_in),
    .busy       (busy),
    .spin       (spin),
    .spin_valid (spin_valid),
    .spin_ready (spin_ready)
  );

  always #5 clk = ~clk;

  // Oscillator value seen at edge k, counting the start edge as k=0.
  function automatic logic [N-1:0] pat(input int mode, input int k);
    logic [N-1:0] p;
    p = '0;
    case (mode)
      MODE_MAXCUT: p = (k % 2 == 0) ? 6'b101101 : 6'b010010;
      MODE_TIE4:   p[0] = (k % 2 == 1);
      MODE_MAJ5:   p[0] = !(k == 4 || k == 6 || k == 8);
      default:     p = 6'b001101;
    endcase
    return p;
  endfunction

  function automatic logic [N-2:0] canon(input logic [N-2:0] x);
`ifdef ISING_READOUT_CANON_EN
    return x[0] ? ~x : x;
`else
    return x;
`endif
  endfunction

  task automatic run_readout(input int mode, input logic [N-2:0] raw_exp,
                             input bit mid_start, input string tag);
    int lat;
    logic [N-2:0] want;
    @(negedge clk);
    osc_in = pat(mode, 0);
    start  = 1'b1;
    exp_q.push_back(canon(raw_exp));
    lat = -1;
    for (int cyc = 1; cyc <= LAT + 10; cyc++) begin
      @(negedge clk);
      start  = mid_start && (cyc == 8);
      osc_in = pat(mode, cyc);
      @(posedge clk);
      #1;
      if (spin_valid) begin
        lat = cyc;
        break;
      end
    end
    start = 1'b0;
    checks++;
    if (lat != LAT) begin
      failures++;
      $display("FAIL %s_latency got=%0d want=%0d", tag, lat, LAT);
    end
    want = exp_q.pop_front();
    checks++;
    if (spin !== want) begin
      failures++;
      $display("FAIL %s_spin got=%b want=%b", tag, spin, want);
    end
  endtask

  task automatic check_release(input logic [N-2:0] want, input string tag);
    @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || spin_valid !== 1'b0 || spin !== want) begin
      failures++;
      $display("FAIL %s_release got busy=%b valid=%b spin=%b want 0 0 %b",
               tag, busy, spin_valid, spin, want);
    end
  endtask

  task automatic test_reset();
    #2 rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || spin_valid !== 1'b0 || spin !== '0) begin
      failures++;
      $display("FAIL reset got busy=%b valid=%b spin=%b want 0 0 0", busy, spin_valid, spin);
    end
    @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_reset got busy=%b want 0", busy);
    end
  endtask

  task automatic test_maxcut();
    spin_ready = 1'b1;
    run_readout(MODE_MAXCUT, 5'b10010, 1'b0, "maxcut");
    check_release(canon(5'b10010), "maxcut");
  endtask

  task automatic test_backpressure();
    int bad;
    spin_ready = 1'b0;
    run_readout(MODE_RAW, 5'b01101, 1'b0, "bp");
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (spin_valid !== 1'b1 || busy !== 1'b1 || spin !== canon(5'b01101)) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL bp_hold got %0d unstable cycles want 0", bad);
    end
    @(negedge clk);
    spin_ready = 1'b1;
    check_release(canon(5'b01101), "bp");
  endtask

  task automatic test_tie();
    spin_ready = 1'b1;
    run_readout(MODE_TIE4, 5'b00000, 1'b0, "tie4");
    check_release(canon(5'b00000), "tie4");
    run_readout(MODE_MAJ5, 5'b00001, 1'b0, "maj5");
    check_release(canon(5'b00001), "maj5");
  endtask

  task automatic test_mid_start();
    int busy_seen;
    spin_ready = 1'b1;
    run_readout(MODE_MAXCUT, 5'b10010, 1'b1, "midstart");
    check_release(canon(5'b10010), "midstart");
    busy_seen = 0;
    for (int i = 0; i < LAT + 3; i++) begin
      @(posedge clk);
      #1;
      if (busy !== 1'b0) busy_seen++;
    end
    checks++;
    if (busy_seen != 0) begin
      failures++;
      $display("FAIL midstart_queued got %0d busy cycles want 0", busy_seen);
    end
  endtask

  task automatic test_reset_mid_sample();
    @(negedge clk);
    osc_in = pat(MODE_RAW, 0);
    start  = 1'b1;
    for (int cyc = 1; cyc <= S + 4; cyc++) begin
      @(negedge clk);
      start  = 1'b0;
      osc_in = pat(MODE_RAW, cyc);
    end
    rstn = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || spin_valid !== 1'b0 || spin !== '0) begin
      failures++;
      $display("FAIL reset_mid got busy=%b valid=%b spin=%b want 0 0 0", busy, spin_valid, spin);
    end
    @(negedge clk);
    rstn = 1'b1;
    run_readout(MODE_MAXCUT, 5'b10010, 1'b0, "after_reset");
    check_release(canon(5'b10010), "after_reset");
  endtask

  initial begin
    test_reset();
    test_maxcut();
    test_backpressure();
    test_tie();
    test_mid_start();
    test_reset_mid_sample();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_leftover got=%0d want=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/ising_readout.md
ISING_READOUT -- requirements
Module: ising_readout

Interface
REQ-001 Parameter N, default 6: number of oscillator cells; cell N-1 is the local-field reference.
REQ-002 Parameter SETTLE_CYCLES, default 64: clk cycles waited after start before sampling begins; legal range 1 or more.
REQ-003 Parameter SAMPLE_CYCLES, default 32: clk cycles over which phases are sampled; legal range 1 or more.
REQ-004 clk  input  1  sampling clock, rising edge.
REQ-005 rstn  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  pulse requesting one readout; ignored unless state is IDLE.
REQ-007 osc_in  input  N  raw oscillator outputs from core_matrix outputs_hor, asynchronous to clk.
REQ-008 busy  output  1  high in every state except IDLE.
REQ-009 spin  output  N-1  solved phases; bit i = 1 means cell i is opposite in phase to the reference.
REQ-010 spin_valid  output  1  spin holds a completed result.
REQ-011 spin_ready  input  1  consumer accepts spin.

Function
REQ-012 osc_in SHALL pass through a 2-flop synchronizer per bit before any use; synchronizer latency is 2 cycles.
REQ-013 FSM states: IDLE, SETTLE, SAMPLE, DONE.
REQ-014 IDLE -> SETTLE on start=1; the settle counter loads 0.
REQ-015 SETTLE counts clk cycles; after exactly SETTLE_CYCLES cycles -> SAMPLE, and all mismatch counters clear.
REQ-016 In each SAMPLE cycle, mismatch counter i increments when sync[i] XOR sync[N-1] is 1, for i = 0..N-2.
REQ-017 Mismatch counters are $clog2(SAMPLE_CYCLES+1) bits wide and SHALL never wrap.
REQ-018 After exactly SAMPLE_CYCLES sample cycles: spin[i] = 1 iff 2*count[i] > SAMPLE_CYCLES; a tie resolves to 0; state -> DONE and spin_valid = 1 on the next cycle.
REQ-019 In DONE, spin SHALL be held stable while spin_valid=1 and spin_ready=0.
REQ-020 DONE -> IDLE on the cycle where spin_valid and spin_ready are both 1; spin_valid drops the following cycle and spin retains its value.
REQ-021 start while busy=1 SHALL be ignored and SHALL NOT queue.
REQ-022 Total latency from the start edge to spin_valid = SETTLE_CYCLES + SAMPLE_CYCLES + 1 cycles.

Reset
REQ-023 rstn=0 SHALL asynchronously force state=IDLE, spin=0, spin_valid=0, busy=0, and clear all counters and synchronizer flops.
REQ-024 Reset asserted mid-SETTLE, mid-SAMPLE, or in DONE SHALL abort the readout; no partial result is presented.

Configuration
REQ-025 With macro ISING_READOUT_CANON_EN defined, the result SHALL be canonicalized before being registered into spin: if raw bit 0 is 1, all N-1 bits are inverted, so spin[0] is always 0.
REQ-026 Without ISING_READOUT_CANON_EN, spin SHALL equal the raw majority result.

Structure
REQ-027 A shared package SHALL hold the FSM state encoding (2-bit typedef: IDLE=0, SETTLE=1, SAMPLE=2, DONE=3) and the default parameter constants.
REQ-028 The synchronizer SHALL be a separate sub-module, sync_2ff, parameterized by width.

Verification
REQ-029 Bench N=6, SETTLE_CYCLES=4, SAMPLE_CYCLES=8. Max-cut case: cells A, C, D in phase with the reference and B, E in anti-phase, start pulsed, spin_ready=1 -> spin=5'b10010 after 13 cycles, then busy falls.
REQ-030 Backpressure: spin_ready held 0 for 20 cycles -> spin_valid stays 1 and spin is stable; raising ready -> IDLE one cycle later.
REQ-031 Tie: cell 0 mismatched in exactly 4 of 8 sample cycles -> spin[0]=0; in 5 of 8 cycles -> spin[0]=1.
REQ-032 Mid-run start: start pulsed during SAMPLE -> ignored; result and latency are unchanged.
REQ-033 Reset during SAMPLE -> all outputs 0 immediately; a new start completes normally.
REQ-034 With ISING_READOUT_CANON_EN defined, raw result 5'b01101 -> spin=5'b10010.
